// File: rtl/ibis_vga_timing_detect.sv
`default_nettype none
// ============================================================================
// Module   : ibis_vga_timing_detect
// Function : Measures raster timing from blanking strobes and locks once
//            consecutive frames agree; reports pixel coordinates when locked.
// Revision : 1.0 - initial release
// ============================================================================
module ibis_vga_timing_detect #(
    parameter int LOCK_FRAMES = 2,
    parameter int MAX_COUNT   = 1023
) (
    input  logic       aclk,
    input  logic       aresetn,
    input  logic       enable,
    input  logic       hsync,
    input  logic       vsync,
    input  logic       hblankn,
    input  logic       vblankn,
    output logic [9:0] ord_x,
    output logic [9:0] ord_y,
    output logic       pixel_valid,
    output logic [9:0] h_total,
    output logic [9:0] h_active,
    output logic [9:0] v_total,
    output logic [9:0] v_active,
    output logic       locked,
    output logic       timing_error
);

    localparam logic [1:0] c_search  = 2'd0;
    localparam logic [1:0] c_measure = 2'd1;
    localparam logic [1:0] c_check   = 2'd2;
    localparam logic [1:0] c_locked  = 2'd3;

    localparam logic [9:0] c_max    = 10'(MAX_COUNT);
    localparam logic [9:0] c_max_m1 = 10'(MAX_COUNT - 1);
    localparam logic [3:0] c_lock   = 4'(LOCK_FRAMES);

    logic [1:0] r_state, w_state_nxt;
    logic       r_hb, r_vb, r_vb_line;
    logic [9:0] r_x_cnt, r_hact, r_y_cnt, r_vact;
    logic [3:0] r_match;
    logic [9:0] r_h_total, r_h_active, r_v_total, r_v_active;
    logic       r_terr;

    logic       w_ls, w_fs;
    logic       w_x_inc, w_hact_inc, w_y_inc, w_vact_inc;
    logic       w_sat, w_sync_bad, w_line_ok, w_frame_ok;
    logic [9:0] w_line_len, w_line_act, w_frame_len, w_frame_act;
    logic       w_err, w_latch, w_match_inc, w_match_clr;

    assign w_ls = enable & hblankn & ~r_hb;
    assign w_fs = w_ls & vblankn & ~r_vb_line;

    assign w_x_inc    = enable & ~w_ls;
    assign w_hact_inc = w_x_inc & hblankn;
    assign w_y_inc    = w_ls & ~w_fs;
    assign w_vact_inc = w_y_inc & vblankn;

    // Counters restart at 0 on the start event, so each length is count + 1.
    assign w_line_len  = r_x_cnt + 10'd1;
    assign w_line_act  = r_hact + 10'd1;
    assign w_frame_len = r_y_cnt + 10'd1;
    assign w_frame_act = r_vact + 10'd1;

    assign w_line_ok  = (w_line_len == r_h_total) && (w_line_act == r_h_active);
    assign w_frame_ok = (w_frame_len == r_v_total) && (w_frame_act == r_v_active);

    assign w_sat = (w_x_inc & (r_x_cnt == c_max_m1)) | (w_hact_inc & (r_hact == c_max_m1)) |
                   (w_y_inc & (r_y_cnt == c_max_m1)) | (w_vact_inc & (r_vact == c_max_m1));

    assign w_sync_bad = enable & ((~hsync & hblankn) | (~vsync & vblankn));

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_state <= c_search;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_err       = 1'b0;
        w_latch     = 1'b0;
        w_match_inc = 1'b0;
        w_match_clr = 1'b0;
        if (enable) begin
            case (r_state)
                c_search: begin
                    if (w_fs) begin
                        w_match_clr = 1'b1;
                        w_state_nxt = c_measure;
                    end
                end
                c_measure: begin
                    if (w_fs) begin
                        w_latch     = 1'b1;
                        w_match_clr = 1'b1;
                        w_state_nxt = c_check;
                    end
                end
                c_check: begin
                    if (w_fs) begin
                        if (w_line_ok && w_frame_ok) begin
                            w_match_inc = 1'b1;
                            if (r_match + 4'd1 == c_lock) begin
                                w_state_nxt = c_locked;
                            end
                        end else begin
                            w_latch     = 1'b1;
                            w_match_clr = 1'b1;
                        end
                    end
                end
                c_locked: begin
                    if ((w_ls && !w_line_ok) || (w_fs && !w_frame_ok) || w_sync_bad) begin
                        w_err       = 1'b1;
                        w_state_nxt = c_search;
                    end
                end
                default: w_state_nxt = c_search;
            endcase
            // Saturation overrides everything and keeps the last good measurements.
            if (w_sat) begin
                w_err       = 1'b1;
                w_latch     = 1'b0;
                w_match_inc = 1'b0;
                w_match_clr = 1'b0;
                w_state_nxt = c_search;
            end
        end
    end

    always_comb begin
        locked      = (r_state == c_locked);
        pixel_valid = r_hb & r_vb & (r_state == c_locked);
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_hb       <= 1'b0;
            r_vb       <= 1'b0;
            r_vb_line  <= 1'b1;
            r_x_cnt    <= 10'd0;
            r_hact     <= 10'd0;
            r_y_cnt    <= 10'd0;
            r_vact     <= 10'd0;
            r_match    <= 4'd0;
            r_h_total  <= 10'd0;
            r_h_active <= 10'd0;
            r_v_total  <= 10'd0;
            r_v_active <= 10'd0;
            r_terr     <= 1'b0;
        end else begin
            r_terr <= w_err;
            if (enable) begin
                r_hb <= hblankn;
                r_vb <= vblankn;
                if (w_ls) begin
                    r_vb_line <= vblankn;
                    r_x_cnt   <= 10'd0;
                    r_hact    <= 10'd0;
                end else begin
                    if (r_x_cnt != c_max) r_x_cnt <= r_x_cnt + 10'd1;
                    if (hblankn && (r_hact != c_max)) r_hact <= r_hact + 10'd1;
                end
                if (w_fs) begin
                    r_y_cnt <= 10'd0;
                    r_vact  <= 10'd0;
                end else if (w_ls) begin
                    if (r_y_cnt != c_max) r_y_cnt <= r_y_cnt + 10'd1;
                    if (vblankn && (r_vact != c_max)) r_vact <= r_vact + 10'd1;
                end
                if (w_latch) begin
                    r_h_total  <= w_line_len;
                    r_h_active <= w_line_act;
                    r_v_total  <= w_frame_len;
                    r_v_active <= w_frame_act;
                end
                if (w_match_clr) begin
                    r_match <= 4'd0;
                end else if (w_match_inc) begin
                    r_match <= r_match + 4'd1;
                end
            end
        end
    end

    assign ord_x        = r_x_cnt;
    assign ord_y        = r_y_cnt;
    assign h_total      = r_h_total;
    assign h_active     = r_h_active;
    assign v_total      = r_v_total;
    assign v_active     = r_v_active;
    assign timing_error = r_terr;

endmodule
`default_nettype wire

// File: tb/tb_ibis_vga_timing_detect.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_ibis_vga_timing_detect
// Function : Self-checking bench on a scaled-down raster (20x12 total,
//            16x8 active) so every scenario fits a short run.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ibis_vga_timing_detect;

    localparam int LOCK_FRAMES = 2;
    localparam int H_TOT  = 20;
    localparam int H_ACT  = 16;
    localparam int HS_BEG = 17;
    localparam int HS_END = 19;
    localparam int V_TOT  = 12;
    localparam int V_ACT  = 8;
    localparam int VS_BEG = 9;
    localparam int VS_END = 10;

    logic       aclk = 1'b0;
    logic       aresetn, enable, hsync, vsync, hblankn, vblankn;
    logic [9:0] ord_x, ord_y, h_total, h_active, v_total, v_active;
    logic       pixel_valid, locked, timing_error;

    ibis_vga_timing_detect #(
        .LOCK_FRAMES (LOCK_FRAMES),
        .MAX_COUNT   (1023)
    ) dut (
        .aclk         (aclk),
        .aresetn      (aresetn),
        .enable       (enable),
        .hsync        (hsync),
        .vsync        (vsync),
        .hblankn      (hblankn),
        .vblankn      (vblankn),
        .ord_x        (ord_x),
        .ord_y        (ord_y),
        .pixel_valid  (pixel_valid),
        .h_total      (h_total),
        .h_active     (h_active),
        .v_total      (v_total),
        .v_active     (v_active),
        .locked       (locked),
        .timing_error (timing_error)
    );

    always #5 aclk = ~aclk;

    typedef struct {
        int         line;
        int         pix;
        logic [9:0] x;
        logic [9:0] y;
        logic       pv;
    } vec_t;

    vec_t vtab [8];
    vec_t sbq [$];

    int   n_tests    = 0;
    int   n_fail     = 0;
    int   err_pulses = 0;
    bit   rand_gap   = 1'b0;
    logic [9:0] s_x;
    logic s_terr, s_locked, g_terr;

    always @(negedge aclk) if (timing_error === 1'b1) err_pulses++;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time exhausted, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Drives one pixel with enable high, then idles; sampled just after the edge.
    task automatic drive_pix(input logic hb, input logic vb, input logic hs, input logic vs,
                             input bit probe, input vec_t e);
        int gap;
        hblankn = hb;
        vblankn = vb;
        hsync   = hs;
        vsync   = vs;
        enable  = 1'b1;
        if (probe) sbq.push_back(e);
        @(posedge aclk);
        #1;
        enable   = 1'b0;
        s_x      = ord_x;
        s_terr   = timing_error;
        s_locked = locked;
        if (sbq.size() > 0) begin
            vec_t g;
            g = sbq.pop_front();
            chk($sformatf("ord_x L%0d P%0d", g.line, g.pix), ord_x, g.x);
            chk($sformatf("ord_y L%0d P%0d", g.line, g.pix), ord_y, g.y);
            chk($sformatf("pixel_valid L%0d P%0d", g.line, g.pix), pixel_valid, g.pv);
        end
        gap    = rand_gap ? int'($urandom_range(0, 5)) : 4;
        g_terr = 1'b0;
        for (int i = 0; i < gap; i++) begin
            @(posedge aclk);
            #1;
            if (i == 0) g_terr = timing_error;
        end
    endtask

    task automatic drive_lines(input int first, input int last, input int pstart,
                               input int short_line, input int exp_fs, input bit probe_on);
        for (int l = first; l <= last; l++) begin
            int len;
            len = (l == short_line) ? H_TOT - 1 : H_TOT;
            for (int p = (l == first) ? pstart : 0; p < len; p++) begin
                vec_t e;
                bit   hit;
                hit = 1'b0;
                e   = vtab[0];
                for (int k = 0; k < 8; k++) begin
                    if (probe_on && vtab[k].line == l && vtab[k].pix == p) begin
                        e   = vtab[k];
                        hit = 1'b1;
                    end
                end
                drive_pix(p < H_ACT, l < V_ACT, !(p >= HS_BEG && p < HS_END),
                          !(l >= VS_BEG && l < VS_END), hit, e);
                if (l == 0 && p == 0 && exp_fs >= 0) chk("locked after FS", s_locked, exp_fs);
                if (short_line >= 0 && l == short_line + 1 && p == 0) begin
                    chk("timing_error at short-line LS", s_terr, 1);
                    chk("locked after short line", s_locked, 0);
                    chk("timing_error cleared next cycle", g_terr, 0);
                end
            end
        end
    endtask

    task automatic drive_frame(input int short_line, input int exp_fs, input bit probe_on);
        drive_lines(0, V_TOT - 1, 0, short_line, exp_fs, probe_on);
    endtask

    // Lock must appear exactly at the FS of frame LOCK_FRAMES+2, not earlier.
    task automatic acquire(input bit probe_last);
        for (int k = 1; k <= LOCK_FRAMES + 2; k++) begin
            drive_frame(-1, (k == LOCK_FRAMES + 2) ? 1 : 0, probe_last && (k == LOCK_FRAMES + 2));
        end
    endtask

    task automatic chk_meas(input string tag);
        chk({tag, " h_total"}, h_total, H_TOT);
        chk({tag, " h_active"}, h_active, H_ACT);
        chk({tag, " v_total"}, v_total, V_TOT);
        chk({tag, " v_active"}, v_active, V_ACT);
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, " ord_x"}, ord_x, 0);
        chk({tag, " ord_y"}, ord_y, 0);
        chk({tag, " h_total"}, h_total, 0);
        chk({tag, " h_active"}, h_active, 0);
        chk({tag, " v_total"}, v_total, 0);
        chk({tag, " v_active"}, v_active, 0);
        chk({tag, " locked"}, locked, 0);
        chk({tag, " timing_error"}, timing_error, 0);
        chk({tag, " pixel_valid"}, pixel_valid, 0);
    endtask

    initial begin
        int   base;
        vec_t dummy;
        vtab[0] = '{0,  0,  10'd0,  10'd0,  1'b1};
        vtab[1] = '{3,  0,  10'd0,  10'd3,  1'b1};
        vtab[2] = '{3,  15, 10'd15, 10'd3,  1'b1};
        vtab[3] = '{3,  16, 10'd16, 10'd3,  1'b0};
        vtab[4] = '{5,  7,  10'd7,  10'd5,  1'b1};
        vtab[5] = '{7,  15, 10'd15, 10'd7,  1'b1};
        vtab[6] = '{8,  0,  10'd0,  10'd8,  1'b0};
        vtab[7] = '{11, 19, 10'd19, 10'd11, 1'b0};
        dummy   = vtab[0];

        aresetn = 1'b0;
        enable  = 1'b0;
        hsync   = 1'b1;
        vsync   = 1'b1;
        hblankn = 1'b0;
        vblankn = 1'b0;
        repeat (3) @(posedge aclk);
        #1;
        chk_reset_outs("power-on reset");
        aresetn = 1'b1;

        // Initial acquisition from reset, entering through vertical blanking.
        drive_lines(V_ACT, V_TOT - 1, 0, -1, -1, 1'b0);
        acquire(1'b1);
        chk_meas("first lock");
        chk("no errors during acquisition", err_pulses, 0);

        // One short line while locked, then relock.
        base = err_pulses;
        drive_frame(3, 1, 1'b0);
        chk("single pulse for short line", err_pulses - base, 1);
        chk_meas("after short line");
        acquire(1'b0);
        chk_meas("relock");
        chk("no further errors while relocking", err_pulses - base, 1);

        // Line held active long enough to saturate the pixel counter.
        base = err_pulses;
        drive_lines(0, 4, 0, -1, 1, 1'b0);
        for (int i = 0; i < 1100; i++) begin
            drive_pix(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, dummy);
            if (i == 1022) begin
                chk("ord_x before saturation", s_x, 1022);
                chk("timing_error before saturation", s_terr, 0);
                chk("locked before saturation", s_locked, 1);
            end
            if (i == 1023) begin
                chk("ord_x at saturation", s_x, 1023);
                chk("timing_error at saturation", s_terr, 1);
                chk("locked after saturation", s_locked, 0);
            end
        end
        chk("ord_x held saturated", s_x, 1023);
        chk("single pulse for saturation", err_pulses - base, 1);
        chk_meas("after saturation");
        drive_lines(6, V_TOT - 1, 0, -1, -1, 1'b0);
        acquire(1'b0);

        // Reset in the middle of a locked frame, then resume with random enable gaps.
        drive_lines(0, 3, 0, -1, 1, 1'b0);
        for (int p = 0; p < 6; p++) begin
            drive_pix(p < H_ACT, 1'b1, 1'b1, 1'b1, 1'b0, dummy);
        end
        aresetn = 1'b0;
        hblankn = 1'b1;
        vblankn = 1'b1;
        enable  = 1'b1;
        @(posedge aclk);
        #1;
        enable  = 1'b0;
        chk_reset_outs("mid-frame reset");
        aresetn  = 1'b1;
        rand_gap = 1'b1;
        base     = err_pulses;
        drive_lines(4, V_TOT - 1, 7, -1, -1, 1'b0);
        acquire(1'b1);
        chk_meas("lock with random enable");
        drive_frame(-1, 1, 1'b1);
        chk("no errors with random enable", err_pulses - base, 0);
        chk("still locked with random enable", locked, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
